// File: rtl/adc_stream_decimator_if.sv
// rtl/adc_stream_decimator_if.sv - ADC sample input and averaged-frame output stream bundle
interface adc_stream_decimator_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 8
);
  logic [NUM_CH*DATA_W-1:0] adc_data;
  logic                     adc_valid;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output adc_data, adc_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  adc_data, adc_valid, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/adc_stream_decimator.sv
// rtl/adc_stream_decimator.sv - offset-binary conversion, accumulate-and-dump averaging, FWFT frame FIFO
module adc_stream_decimator #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 8,
  parameter int DECIM_LOG2 = 2,
  parameter bit OFFSET_BIN = 1'b1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic                         enable,
  adc_stream_decimator_if.slave        bus,
  output logic                         overflow,
  input  logic                         clear_ovf,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int ACC_W   = DATA_W + DECIM_LOG2;
  localparam int CNT_W   = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int FRAME_W = NUM_CH * DATA_W;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'((1 << DECIM_LOG2) - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] MSB_FLIP = {OFFSET_BIN, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0]  acc_q [NUM_CH];
  logic signed [ACC_W-1:0]  acc_d [NUM_CH];
  logic signed [ACC_W-1:0]  sum   [NUM_CH];
  logic signed [DATA_W-1:0] smp   [NUM_CH];
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [FRAME_W-1:0]       frame;
  logic [FRAME_W-1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic                     overflow_q, overflow_d;
  logic                     fire, frame_done, pop, full, push, drop;

  assign fire       = enable & bus.adc_valid;
  assign frame_done = fire & (cnt_q == CNT_MAX);
  assign full       = (level_q == LVL_FULL);
  assign pop        = bus.out_valid & bus.out_ready;
  // A full FIFO still takes the new frame when the head leaves on the same edge.
  assign push       = frame_done & (~full | pop);
  assign drop       = frame_done & full & ~pop;

  always_comb begin
    frame = '0;
    cnt_d = cnt_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      smp[ch]   = bus.adc_data[ch*DATA_W +: DATA_W] ^ MSB_FLIP;
      sum[ch]   = acc_q[ch] + ACC_W'(smp[ch]);
      frame[ch*DATA_W +: DATA_W] = DATA_W'(sum[ch] >>> DECIM_LOG2);
      acc_d[ch] = acc_q[ch];
    end
    // Dropping enable abandons any partial frame so the next one starts clean.
    if (!enable) begin
      cnt_d = '0;
      for (int ch = 0; ch < NUM_CH; ch++) acc_d[ch] = '0;
    end else if (fire) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        for (int ch = 0; ch < NUM_CH; ch++) acc_d[ch] = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        for (int ch = 0; ch < NUM_CH; ch++) acc_d[ch] = sum[ch];
      end
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (drop)           overflow_d = 1'b1;
    else if (clear_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      for (int ch = 0; ch < NUM_CH; ch++) acc_q[ch] <= acc_d[ch];
      if (push) mem_q[wr_ptr_q] <= frame;
    end
  end

  assign bus.out_valid = (level_q != '0);
  assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow      = overflow_q;
  assign fifo_level    = level_q;
endmodule

// File: tb/tb_adc_stream_decimator.sv
// tb/tb_adc_stream_decimator.sv - scoreboard bench for adc_stream_decimator (2 ch, 8 bit, /4, depth 4)
module tb_adc_stream_decimator;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       clear_ovf;
  logic       overflow;
  logic [2:0] fifo_level;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [15:0] sb[$];

  adc_stream_decimator_if #(.NUM_CH(2), .DATA_W(8)) bus ();

  adc_stream_decimator #(
    .NUM_CH(2), .DATA_W(8), .DECIM_LOG2(2), .OFFSET_BIN(1'b1), .FIFO_DEPTH(4)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable), .bus(bus),
    .overflow(overflow), .clear_ovf(clear_ovf), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // floor of the mean of four offset-binary samples, as a two's-complement byte
  function automatic logic [7:0] avg4(input logic [3:0][7:0] v);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'($signed(v[i] ^ 8'h80));
    return 8'(s >>> 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [3:0][7:0] c0, input logic [3:0][7:0] c1,
                            input bit expect_push, input bit rdy_on_last);
    for (int i = 0; i < 4; i++) begin
      bus.adc_data  = {c1[i], c0[i]};
      bus.adc_valid = 1'b1;
      if (i == 3) begin
        if (expect_push) sb.push_back({avg4(c1), avg4(c0)});
        if (rdy_on_last) bus.out_ready = 1'b1;
      end
      tick();
    end
    bus.adc_valid = 1'b0;
    if (rdy_on_last) bus.out_ready = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (!bus.out_valid) done = 1'b1;
    end
    bus.out_ready = 1'b0;
    total_cnt++;
    if (!done || sb.size() != 0)
      $display("FAIL drain: out_valid=%0b queued=%0d, required out_valid=0 queued=0",
               bus.out_valid, sb.size());
    else pass_cnt++;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_frame: got %h, required none", bus.out_data);
      end else begin
        logic [15:0] exp_frame;
        exp_frame = sb.pop_front();
        if (bus.out_data !== exp_frame)
          $display("FAIL frame_order: got %h, required %h", bus.out_data, exp_frame);
        else pass_cnt++;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; clear_ovf = 1'b0;
    bus.adc_data = '0; bus.adc_valid = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    total_cnt += 4;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", bus.out_valid);
    else pass_cnt++;
    if (bus.out_data !== 16'h0) $display("FAIL reset_data: got %h, required 0000", bus.out_data);
    else pass_cnt++;
    if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b, required 0", overflow);
    else pass_cnt++;
    if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d, required 0", fifo_level);
    else pass_cnt++;
    rst_n = 1'b1; enable = 1'b1;
  endtask

  task automatic test_basic();
    send_frame({8'h83, 8'h82, 8'h81, 8'h80}, {4{8'h00}}, 1'b1, 1'b0);
    total_cnt += 2;
    if (bus.out_valid !== 1'b1) $display("FAIL basic_latency: got out_valid=%b, required 1", bus.out_valid);
    else pass_cnt++;
    if (bus.out_data !== 16'h8001) $display("FAIL basic_data: got %h, required 8001", bus.out_data);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_floor();
    send_frame({8'h80, 8'h80, 8'h80, 8'h7F}, {4{8'hFF}}, 1'b1, 1'b0);
    total_cnt++;
    if (bus.out_data !== 16'h7FFF) $display("FAIL floor_data: got %h, required 7FFF", bus.out_data);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_overflow();
    logic [3:0][7:0] c0, c1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        c0[i] = 8'(8'h90 + 16 * k + i);
        c1[i] = 8'(8'h10 * k + 3 * i);
      end
      send_frame(c0, c1, k < 4, 1'b0);
    end
    total_cnt += 3;
    if (fifo_level !== 3'd4) $display("FAIL ovf_level: got %0d, required 4", fifo_level);
    else pass_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_set: got %b, required 1", overflow);
    else pass_cnt++;
    tick();
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", overflow);
    else pass_cnt++;
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b, required 0", overflow);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_full_pop();
    logic [3:0][7:0] c0, c1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        c0[i] = 8'(8'h20 + 8 * k + 5 * i);
        c1[i] = 8'(8'hC0 - 8 * k - i);
      end
      if (k == 4) begin
        total_cnt++;
        if (fifo_level !== 3'd4) $display("FAIL fullpop_pre_level: got %0d, required 4", fifo_level);
        else pass_cnt++;
      end
      send_frame(c0, c1, 1'b1, k == 4);
    end
    total_cnt += 2;
    if (fifo_level !== 3'd4) $display("FAIL fullpop_level: got %0d, required 4", fifo_level);
    else pass_cnt++;
    if (overflow !== 1'b0) $display("FAIL fullpop_ovf: got %b, required 0", overflow);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_enable();
    for (int i = 0; i < 2; i++) begin
      bus.adc_data = 16'hF0F0; bus.adc_valid = 1'b1;
      tick();
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.adc_data = 16'hFFFF;
      tick();
    end
    enable = 1'b1; bus.adc_valid = 1'b0;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL enable_idle: got out_valid=%b, required 0", bus.out_valid);
    else pass_cnt++;
    send_frame({4{8'h84}}, {4{8'h84}}, 1'b1, 1'b0);
    total_cnt += 2;
    if (bus.out_data !== 16'h0404) $display("FAIL enable_data: got %h, required 0404", bus.out_data);
    else pass_cnt++;
    if (fifo_level !== 3'd1) $display("FAIL enable_level: got %0d, required 1", fifo_level);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) send_frame({4{8'(8'hA0 + k)}}, {4{8'h40}}, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      bus.adc_data = 16'h7070; bus.adc_valid = 1'b1;
      tick();
    end
    total_cnt++;
    if (fifo_level !== 3'd3) $display("FAIL midrst_pre_level: got %0d, required 3", fifo_level);
    else pass_cnt++;
    bus.adc_valid = 1'b0; rst_n = 1'b0;
    tick();
    total_cnt += 4;
    if (bus.out_valid !== 1'b0) $display("FAIL midrst_valid: got %b, required 0", bus.out_valid);
    else pass_cnt++;
    if (bus.out_data !== 16'h0) $display("FAIL midrst_data: got %h, required 0000", bus.out_data);
    else pass_cnt++;
    if (fifo_level !== 3'd0) $display("FAIL midrst_level: got %0d, required 0", fifo_level);
    else pass_cnt++;
    if (overflow !== 1'b0) $display("FAIL midrst_ovf: got %b, required 0", overflow);
    else pass_cnt++;
    rst_n = 1'b1;
    send_frame({4{8'h88}}, {4{8'h88}}, 1'b1, 1'b0);
    total_cnt++;
    if (bus.out_data !== 16'h0808) $display("FAIL midrst_frame: got %h, required 0808", bus.out_data);
    else pass_cnt++;
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_floor();
    test_overflow();
    test_full_pop();
    test_enable();
    test_reset_mid();
    tick();
    total_cnt++;
    if (sb.size() != 0) $display("FAIL scoreboard_empty: got %0d queued, required 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
